// File: rtl/multu_hilo.sv
// Sequential unsigned WIDTHxWIDTH multiplier (shift-and-add, one multiplier bit per clock)
// owning the HI/LO register pair that feeds the ALU output mux.
module multu_hilo #(
   parameter int          WIDTH       = 32,
   parameter logic [5:0]  MULTU_FUNCT = 6'b011011
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   input  logic [5:0]       Signal,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_reg;
   logic [2*WIDTH-1:0] mcand_reg;
   logic [2*WIDTH-1:0] prod_reg;
   logic [WIDTH-1:0]   mplr_reg;
   logic [CW-1:0]      cnt_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;

   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] sum;
   logic               start;

   // Multiplicand gated by the current multiplier LSB.
   genvar gi;
   generate
      for (gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
         assign addend[gi] = mcand_reg[gi] & mplr_reg[0];
      end
   endgenerate

   assign sum   = prod_reg + addend;
   assign start = (state_reg != RUN) && (Signal == MULTU_FUNCT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         mcand_reg <= '0;
         prod_reg  <= '0;
         mplr_reg  <= '0;
         cnt_reg   <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  mcand_reg <= {{WIDTH{1'b0}}, dataA};
                  mplr_reg  <= dataB;
                  prod_reg  <= '0;
                  cnt_reg   <= '0;
                  state_reg <= RUN;
               end else begin
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               prod_reg  <= sum;
               mcand_reg <= mcand_reg << 1;
               mplr_reg  <= mplr_reg >> 1;
               cnt_reg   <= cnt_reg + CW'(1);
               // Final edge: HI/LO take the sum including this edge's add.
               if (cnt_reg == LAST_CNT) begin
                  hi_reg    <= sum[2*WIDTH-1:WIDTH];
                  lo_reg    <= sum[WIDTH-1:0];
                  state_reg <= DONE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign HiOut = hi_reg;
   assign LoOut = lo_reg;
   assign busy  = (state_reg == RUN);
   assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_multu_hilo.sv
// Scoreboard bench for multu_hilo: expected HI:LO pushed at start, popped on each done pulse.
module tb_multu_hilo;

   localparam logic [5:0] MULTU = 6'b011011;
   localparam logic [5:0] MFHI  = 6'b010000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] dataA, dataB;
   logic [5:0]  Signal;
   logic [31:0] HiOut, LoOut;
   logic        busy, done;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q[$];

   multu_hilo dut (
      .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB), .Signal(Signal),
      .HiOut(HiOut), .LoOut(LoOut), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done: got HI=%h LO=%h, no result expected", HiOut, LoOut);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({HiOut, LoOut} !== e) begin
               errors++;
               $display("FAIL sb_result: got %h_%h expected %h_%h", HiOut, LoOut, e[63:32], e[31:0]);
            end else
               $display("result HI=%h LO=%h ok", HiOut, LoOut);
         end
      end
   end

   task automatic start_mult(input logic [31:0] a, input logic [31:0] b);
      dataA  = a;
      dataB  = b;
      Signal = MULTU;
      exp_q.push_back(64'(a) * 64'(b));
      $display("start %h x %h", a, b);
      @(negedge clk);
      Signal = 6'b000000;
   endtask

   // Waits for done from just after a start edge; checks busy length and HI/LO hold.
   task automatic wait_done(input string name);
      int n = 0;
      int nbusy = 0;
      bit held = 1'b1;
      logic [31:0] ph, pl;
      ph = HiOut;
      pl = LoOut;
      while (done !== 1'b1 && n < 100) begin
         if (busy === 1'b1) nbusy++;
         if (HiOut !== ph || LoOut !== pl) held = 1'b0;
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL %s_timeout: done not seen after %0d cycles", name, n);
      end
      checks++;
      if (nbusy != 32) begin
         errors++;
         $display("FAIL %s_busy_len: got %0d busy cycles expected 32", name, nbusy);
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL %s_hold: HI/LO changed during RUN (got %b expected 1)", name, held);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; Signal = '0; dataA = '0; dataB = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({HiOut, LoOut, busy, done} !== 66'b0) begin
         errors++;
         $display("FAIL reset_state: got HI=%h LO=%h busy=%b done=%b expected all 0", HiOut, LoOut, busy, done);
      end
      Signal = MFHI; dataA = 32'd9; dataB = 32'd9;
      repeat (5) @(negedge clk);
      checks++;
      if ({HiOut, LoOut, busy, done} !== 66'b0) begin
         errors++;
         $display("FAIL reset_mfhi_ignored: got HI=%h LO=%h busy=%b done=%b expected all 0", HiOut, LoOut, busy, done);
      end
      Signal = '0;
      $display("reset test complete");
   endtask

   task automatic test_basic();
      start_mult(32'd3, 32'd5);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy_rise: got %b expected 1", busy);
      end
      wait_done("basic");
      checks++;
      if ({HiOut, LoOut} !== 64'h0000_0000_0000_000F) begin
         errors++;
         $display("FAIL basic_const: got %h_%h expected 00000000_0000000f", HiOut, LoOut);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done, busy);
      end
   endtask

   task automatic test_max();
      start_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("max");
      checks++;
      if ({HiOut, LoOut} !== 64'hFFFF_FFFE_0000_0001) begin
         errors++;
         $display("FAIL max_const: got %h_%h expected fffffffe_00000001", HiOut, LoOut);
      end
      @(negedge clk);
      start_mult(32'h0, 32'hFFFF_FFFF);
      wait_done("zero");
      @(negedge clk);
   endtask

   task automatic test_ignore_run_start();
      start_mult(32'h8000_0000, 32'd2);
      dataA = 32'd7; dataB = 32'd7; Signal = MULTU;
      exp_q.push_back(64'd49);
      wait_done("ignore");
      checks++;
      if ({HiOut, LoOut} !== 64'h0000_0001_0000_0000) begin
         errors++;
         $display("FAIL ignore_const: got %h_%h expected 00000001_00000000", HiOut, LoOut);
      end
      @(negedge clk);
      Signal = '0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL ignore_restart_from_done: got busy=%b expected 1", busy);
      end
      wait_done("restart");
      checks++;
      if ({HiOut, LoOut} !== 64'h0000_0000_0000_0031) begin
         errors++;
         $display("FAIL restart_const: got %h_%h expected 00000000_00000031", HiOut, LoOut);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      bit saw_done = 1'b0;
      start_mult(32'h8000_0000, 32'd2);
      wait_done("pre_abort");
      @(negedge clk);
      dataA = 32'd5; dataB = 32'd5; Signal = MULTU;
      @(negedge clk);
      Signal = '0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({HiOut, LoOut, busy, done} !== 66'b0) begin
         errors++;
         $display("FAIL abort_state: got HI=%h LO=%h busy=%b done=%b expected all 0", HiOut, LoOut, busy, done);
      end
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) saw_done = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL abort_no_done: got done pulse, expected none");
      end
      start_mult(32'd6, 32'd7);
      wait_done("post_abort");
      checks++;
      if (LoOut !== 32'h2A) begin
         errors++;
         $display("FAIL post_abort_lo: got %h expected 0000002a", LoOut);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      start_mult(32'h1234_5678, 32'h9ABC_DEF0);
      wait_done("b2b_first");
      checks++;
      if ({HiOut, LoOut} !== 64'h0B00_EA4E_242D_2080) begin
         errors++;
         $display("FAIL b2b_const: got %h_%h expected 0b00ea4e_242d2080", HiOut, LoOut);
      end
      start_mult(32'hDEAD_BEEF, 32'h0000_1234);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_no_gap: got busy=%b expected 1", busy);
      end
      wait_done("b2b_second");
      @(negedge clk);
   endtask

   initial begin
      Signal = '0; dataA = '0; dataB = '0; reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_max();
      test_ignore_run_start();
      test_reset_mid_run();
      test_back_to_back();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending results expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
